// File: rtl/dma_xfer_engine_pkg.sv
// rtl/dma_xfer_engine_pkg.sv - shared state encoding and command field layout
// Purpose: FSM state type and bit positions of the 25-bit transfer command
//          decoded by the system control block.
// Ports:   none (package).
package dma_xfer_engine_pkg;

  localparam int CMD_W        = 25;
  localparam int CMD_MODE_BIT = 24;
  localparam int CMD_SRC_MSB  = 23;
  localparam int CMD_SRC_LSB  = 16;
  localparam int CMD_DST_MSB  = 15;
  localparam int CMD_DST_LSB  = 8;
  localparam int CMD_LEN_MSB  = 7;
  localparam int CMD_LEN_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_READ    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_RELEASE = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/dma_xfer_engine_if.sv
// rtl/dma_xfer_engine_if.sv - command handshake, bus arbitration and memory bus bundle
// Purpose: groups the command inputs, hold/hlda arbitration pair and the
//          8-bit memory bus between the engine and its environment.
// Ports:   master = engine side (drives cmd_ready, hold, mem_*),
//          slave  = control block / processor / memory side.
interface dma_xfer_engine_if #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = 8
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [LW-1:0] cmd_len;
  logic          hold;
  logic          hlda;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len, hlda, mem_rdata,
    output cmd_ready, hold, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dst, cmd_len, hlda, mem_rdata,
    input  cmd_ready, hold, mem_addr, mem_rd, mem_wr, mem_wdata
  );

endinterface

// File: rtl/dma_xfer_engine.sv
// rtl/dma_xfer_engine.sv - DMA byte-copy engine with hold/hlda bus arbitration
// Purpose: accepts {src, dst, len}, requests the bus, then copies len bytes
//          ascending from src to dst at 3 cycles/byte, pulsing done at the end.
// Ports:   clock, reset_n (sync, active low); bus (master modport: command
//          handshake, hold/hlda, memory bus); busy (not idle); done (1-cycle pulse).
module dma_xfer_engine
  import dma_xfer_engine_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  dma_xfer_engine_if.master  bus,
  output logic               busy,
  output logic               done
);

  state_t        state, state_n;
  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic [LW-1:0] count;

  assign bus.cmd_ready = (state == ST_IDLE);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (bus.cmd_valid) state_n = (bus.cmd_len == '0) ? ST_DONE : ST_REQ;
      ST_REQ:     if (bus.hlda) state_n = ST_READ;
      ST_READ:    state_n = ST_CAPTURE;
      ST_CAPTURE: state_n = ST_WRITE;
      // A lost grant only takes effect between bytes: park in REQ with hold still up.
      ST_WRITE: begin
        if (count == LW'(1))  state_n = ST_RELEASE;
        else if (bus.hlda)    state_n = ST_READ;
        else                  state_n = ST_REQ;
      end
      ST_RELEASE: if (!bus.hlda) state_n = ST_DONE;
      ST_DONE:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      src_ptr       <= '0;
      dst_ptr       <= '0;
      count         <= '0;
      bus.hold      <= 1'b0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state <= state_n;

      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            src_ptr <= bus.cmd_src;
            dst_ptr <= bus.cmd_dst;
            count   <= bus.cmd_len;
          end
        end
        // mem_wdata doubles as the byte holding register: captured here,
        // presented unchanged during the following WRITE.
        ST_CAPTURE: bus.mem_wdata <= bus.mem_rdata;
        ST_WRITE: begin
          src_ptr <= src_ptr + AW'(1);
          dst_ptr <= dst_ptr + AW'(1);
          if (count != '0) count <= count - LW'(1);
        end
        default: ;
      endcase

      // Moore outputs are registered from the next state so they line up
      // with the state they belong to.
      bus.hold   <= (state_n == ST_REQ) || (state_n == ST_READ) ||
                    (state_n == ST_CAPTURE) || (state_n == ST_WRITE);
      bus.mem_rd <= (state_n == ST_READ);
      bus.mem_wr <= (state_n == ST_WRITE);
      busy       <= (state_n != ST_IDLE);
      done       <= (state_n == ST_DONE);

      // Going WRITE -> READ the source pointer advances on this same edge,
      // so the next read address is the incremented value.
      if (state_n == ST_READ)
        bus.mem_addr <= (state == ST_WRITE) ? src_ptr + AW'(1) : src_ptr;
      else if (state_n == ST_WRITE)
        bus.mem_addr <= dst_ptr;
    end
  end

endmodule
